program_launcher: RTL and testbench

Host-side sequencer for the start/done handshake of the processor top level. It runs the processor's three programs in order: it holds start high, releases it to launch a program, waits for done, and records how many cycles each program took. A timeout guards against a program that never halts. It replaces manual start/done toggling in benches and on-board bring-up.

---
 rtl/program_launcher.sv | 143 ++++++++++++++
 tb/tb_program_launcher.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/program_launcher.sv
// program_launcher: sequences start/done handshakes for NUM_PROGRAMS programs.
// Optional macro PROGRAM_LAUNCHER_DONE_SYNC_EN adds a 2-flop done synchronizer.
module program_launcher #(
    parameter int NUM_PROGRAMS = 3,
    parameter int START_HOLD   = 2,
    parameter int TIMEOUT      = 1000000,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             done,
    output logic             start,
    output logic [1:0]       prog_idx,
    output logic             busy,
    output logic             result_valid,
    output logic [1:0]       result_idx,
    output logic [CNT_W-1:0] result_cycles,
    output logic             all_done,
    output logic             timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_ASSERT, S_RUN, S_RECORD, S_FINISH, S_ERROR
    } state_t;

    localparam int HW = $clog2(START_HOLD + 1);
    localparam logic [HW-1:0] LP_HOLD_LAST = HW'(START_HOLD - 1);
    localparam logic [1:0]    LP_LAST_PROG = 2'(NUM_PROGRAMS - 1);
    localparam logic [63:0]   LP_TO_LAST   = 64'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [HW-1:0]    r_hold_cnt;
    logic [CNT_W-1:0] r_run_cnt;
    logic [1:0]       r_prog_idx;
    logic [CNT_W-1:0] r_result_cycles;
    logic             r_all_done;
    logic             r_timeout_err;
    logic             w_done;
    logic             w_go_ok;
    logic             w_timeout;
    logic             w_last;

`ifdef PROGRAM_LAUNCHER_DONE_SYNC_EN
    logic [1:0] r_done_sync;

    // Two-flop synchronizer for a done arriving from another clock domain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_done_sync <= 2'b00;
        else       r_done_sync <= {r_done_sync[0], done};
    end

    assign w_done = r_done_sync[1];
`else
    assign w_done = done;
`endif

    assign w_go_ok = go && (r_state == S_IDLE ||
                            r_state == S_FINISH ||
                            r_state == S_ERROR);
    assign w_timeout = (64'(r_run_cnt) == LP_TO_LAST);
    assign w_last    = (r_prog_idx == LP_LAST_PROG);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic; done beats timeout in the same cycle
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_FINISH, S_ERROR:
                if (go) w_next = S_ASSERT;
            S_ASSERT:
                if (r_hold_cnt >= LP_HOLD_LAST) w_next = S_RUN;
            S_RUN:
                if (w_done)         w_next = S_RECORD;
                else if (w_timeout) w_next = S_ERROR;
            S_RECORD:
                w_next = w_last ? S_FINISH : S_ASSERT;
            default:
                w_next = S_IDLE;
        endcase
    end

    // Outputs; reset forces start high without waiting for a clock
    always_comb begin
        start        = 1'b1;
        busy         = 1'b0;
        result_valid = 1'b0;
        if (r_state == S_RUN && !reset) start = 1'b0;
        if (r_state == S_ASSERT || r_state == S_RUN ||
            r_state == S_RECORD) busy = 1'b1;
        if (r_state == S_RECORD) result_valid = 1'b1;
    end

    // Counters, program index, captured result and sticky flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold_cnt      <= '0;
            r_run_cnt       <= '0;
            r_prog_idx      <= '0;
            r_result_cycles <= '0;
            r_all_done      <= 1'b0;
            r_timeout_err   <= 1'b0;
        end else begin
            if (w_go_ok) begin
                r_hold_cnt    <= '0;
                r_prog_idx    <= '0;
                r_all_done    <= 1'b0;
                r_timeout_err <= 1'b0;
            end
            if (r_state == S_ASSERT) begin
                r_run_cnt <= '0;
                if (r_hold_cnt != LP_HOLD_LAST) r_hold_cnt <= r_hold_cnt + 1'b1;
            end
            if (r_state == S_RUN) begin
                if (w_done) begin
                    r_result_cycles <= r_run_cnt;
                end else begin
                    if (!(&r_run_cnt)) r_run_cnt <= r_run_cnt + 1'b1;
                    if (w_timeout) r_timeout_err <= 1'b1;
                end
            end
            if (r_state == S_RECORD) begin
                // RECORD itself is the first start-high hold cycle
                r_hold_cnt <= HW'(1);
                if (w_last) r_all_done <= 1'b1;
                else        r_prog_idx <= r_prog_idx + 1'b1;
            end
        end
    end

    assign prog_idx      = r_prog_idx;
    assign result_idx    = r_prog_idx;
    assign result_cycles = r_result_cycles;
    assign all_done      = r_all_done;
    assign timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_program_launcher.sv
// tb_program_launcher: scoreboard bench with a simple processor model.
// Expected results are queued at launch and popped on result_valid.
module tb_program_launcher;

`ifdef PROGRAM_LAUNCHER_DONE_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        go;
    logic        done;
    logic        start;
    logic [1:0]  prog_idx;
    logic        busy;
    logic        result_valid;
    logic [1:0]  result_idx;
    logic [31:0] result_cycles;
    logic        all_done;
    logic        timeout_err;

    program_launcher #(
        .NUM_PROGRAMS(3),
        .START_HOLD(2),
        .TIMEOUT(50),
        .CNT_W(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .go(go),
        .done(done),
        .start(start),
        .prog_idx(prog_idx),
        .busy(busy),
        .result_valid(result_valid),
        .result_idx(result_idx),
        .result_cycles(result_cycles),
        .all_done(all_done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Processor model: counts cycles since start fell, halts at halts[idx]
    int halts [3];
    bit stale;
    int pc;

    always @(posedge clk) begin
        if (start) pc <= 0;
        else       pc <= pc + 1;
    end

    assign done = start ? stale : (pc >= halts[prog_idx]);

    typedef struct {
        logic [1:0]  idx;
        logic [31:0] cyc;
    } exp_t;

    exp_t sbq [$];
    exp_t e;
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic check(input string tag, input longint got,
                         input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", tag, got, exp);
    endtask

    // Monitor: scoreboard pops, start-hold length, RUN length
    int hi_cnt = 0;
    int lo_cnt = 0;
    int last_lo = 0;
    bit prev_start = 1'b1;
    bit prev_ad = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (result_valid) begin
                if (sbq.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check("result_idx", result_idx, e.idx);
                    check("result_cycles", result_cycles, e.cyc);
                end
            end
            if (all_done && !prev_ad) check("busy_at_all_done", busy, 0);
            if (!start && prev_start) check("start_hold", hi_cnt, 2);
            hi_cnt = (start && busy) ? hi_cnt + 1 : 0;
            if (!start) begin
                lo_cnt++;
            end else begin
                if (!prev_start) last_lo = lo_cnt;
                lo_cnt = 0;
            end
            prev_start = start;
            prev_ad = all_done;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic launch(input int h0, input int h1, input int h2,
                          input int n_exp);
        int h [3];
        h[0] = h0; h[1] = h1; h[2] = h2;
        halts[0] = h0; halts[1] = h1; halts[2] = h2;
        for (int i = 0; i < n_exp; i++) begin
            e.idx = 2'(i);
            if (stale && SYNC != 0) e.cyc = 0;
            else                    e.cyc = 32'(h[i] + SYNC);
            sbq.push_back(e);
        end
        go = 1'b1;
        tick(1);
        go = 1'b0;
        check("go_busy", busy, 1);
        check("go_prog_idx", prog_idx, 0);
        check("go_all_done_clr", all_done, 0);
        check("go_timeout_clr", timeout_err, 0);
    endtask

    task automatic wait_end(input string tag);
        int k = 0;
        while (!(all_done || timeout_err) && k < 500) begin
            tick(1);
            k++;
        end
        if (!(all_done || timeout_err)) check(tag, 0, 1);
        tick(1);
    endtask

    task automatic check_finish(input string tag);
        check({tag, "_all_done"}, all_done, 1);
        check({tag, "_start"}, start, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_timeout"}, timeout_err, 0);
        check({tag, "_prog_idx"}, prog_idx, 2);
        check({tag, "_sb_empty"}, sbq.size(), 0);
    endtask

    initial begin
        int k;
        reset = 1'b1;
        go = 1'b0;
        stale = 1'b0;
        halts[0] = 10; halts[1] = 10; halts[2] = 10;
        #1;
        check("rst_start", start, 1);
        check("rst_prog_idx", prog_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_result_idx", result_idx, 0);
        check("rst_result_cycles", result_cycles, 0);
        check("rst_all_done", all_done, 0);
        check("rst_timeout_err", timeout_err, 0);
        tick(2);
        reset = 1'b0;
        tick(2);

        launch(10, 10, 10, 3);
        wait_end("t1_wait");
        check_finish("t1");

        launch(5, 20, 3, 3);
        wait_end("t2_wait");
        check_finish("t2");

        launch(4, 100000, 4, 1);
        wait_end("t3_wait");
        check("t3_timeout_err", timeout_err, 1);
        check("t3_all_done", all_done, 0);
        check("t3_prog_idx", prog_idx, 1);
        check("t3_start", start, 1);
        check("t3_run_len", last_lo, 50);
        tick(5);
        check("t3_sb_empty", sbq.size(), 0);
        launch(6, 6, 6, 3);
        wait_end("t3b_wait");
        check_finish("t3b");

        stale = 1'b1;
        launch(7, 7, 7, 3);
        wait_end("t4_wait");
        check_finish("t4");
        stale = 1'b0;

        launch(5, 40, 5, 1);
        k = 0;
        while (!(prog_idx == 1 && !start) && k < 200) begin
            tick(1);
            k++;
        end
        check("t5_reach_run1", prog_idx == 1 && !start, 1);
        tick(3);
        go = 1'b1;
        tick(1);
        go = 1'b0;
        check("t5_go_ign_idx", prog_idx, 1);
        check("t5_go_ign_busy", busy, 1);
        check("t5_go_ign_start", start, 0);
        #2 reset = 1'b1;
        #1;
        check("t5_rst_start", start, 1);
        check("t5_rst_prog_idx", prog_idx, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_result_valid", result_valid, 0);
        check("t5_rst_result_cycles", result_cycles, 0);
        check("t5_rst_all_done", all_done, 0);
        check("t5_rst_timeout_err", timeout_err, 0);
        check("t5_sb_empty", sbq.size(), 0);
        tick(2);
        reset = 1'b0;
        tick(2);
        check("t5_idle_busy", busy, 0);
        launch(8, 9, 10, 3);
        wait_end("t5b_wait");
        check_finish("t5b");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
